// File: rtl/alu_shift_arb.sv
// Two-requester round-robin front end for a shared combinational shift unit.
// One operation in flight at a time: accept in IDLE, drive the unit in ISSUE, hold the response in RESP.
module alu_shift_arb #(
    parameter bit MASK_SHAMT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req1_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    output logic [31:0] sh_a,
    output logic [31:0] sh_b,
    output logic [3:0]  sh_opcode,
    output logic        sh_en,
    input  logic [31:0] sh_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_id,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0101, 4'b0110, 4'b0111, 4'b1000: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] fwd_shamt(input logic [31:0] b);
        if (MASK_SHAMT) begin
            fwd_shamt = {27'd0, b[4:0]};
        end else begin
            fwd_shamt = b;
        end
    endfunction

    state_t      state_r;
    logic        ptr_r;
    logic [3:0]  op_r;
    logic        id_r;
    logic [31:0] sh_a_r;
    logic [31:0] sh_b_r;
    logic [3:0]  sh_op_r;
    logic        sh_en_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_data_r;
    logic        rsp_id_r;
    logic        rsp_err_r;

    logic        gnt_id_s;
    logic        accept_s;
    logic [31:0] gnt_a_s;
    logic [31:0] gnt_b_s;
    logic [3:0]  gnt_op_s;

    // Grant selection: lone requester wins, contention resolved by the pointer.
    always_comb begin
        gnt_id_s = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id_s = ptr_r;
        end else begin
            gnt_id_s = req1_valid;
        end
        accept_s = (state_r == IDLE) && !rst && (req0_valid || req1_valid);
        gnt_a_s  = gnt_id_s ? req1_a  : req0_a;
        gnt_b_s  = gnt_id_s ? req1_b  : req0_b;
        gnt_op_s = gnt_id_s ? req1_op : req0_op;
    end

    assign req0_ready = accept_s && !gnt_id_s;
    assign req1_ready = accept_s &&  gnt_id_s;
    assign sh_a       = sh_a_r;
    assign sh_b       = sh_b_r;
    assign sh_opcode  = sh_op_r;
    assign sh_en      = sh_en_r;
    // Gated so a reset arriving mid-response withdraws valid immediately.
    assign rsp_valid  = rsp_valid_r && !rst;
    assign rsp_data   = rsp_data_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_err    = rsp_err_r;

    // Control FSM with latched operation and registered shift-unit/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= 1'b0;
            op_r        <= 4'd0;
            id_r        <= 1'b0;
            sh_a_r      <= 32'd0;
            sh_b_r      <= 32'd0;
            sh_op_r     <= 4'd0;
            sh_en_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'd0;
            rsp_id_r    <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r    <= gnt_op_s;
                        id_r    <= gnt_id_s;
                        ptr_r   <= !gnt_id_s;
                        state_r <= ISSUE;
                        // Illegal opcodes never reach the shift unit.
                        if (is_legal(gnt_op_s)) begin
                            sh_en_r <= 1'b1;
                            sh_a_r  <= gnt_a_s;
                            sh_b_r  <= fwd_shamt(gnt_b_s);
                            sh_op_r <= gnt_op_s;
                        end else begin
                            sh_en_r <= 1'b0;
                            sh_a_r  <= 32'd0;
                            sh_b_r  <= 32'd0;
                            sh_op_r <= 4'd0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    rsp_data_r  <= is_legal(op_r) ? sh_result : 32'd0;
                    rsp_err_r   <= !is_legal(op_r);
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                    sh_en_r     <= 1'b0;
                    sh_a_r      <= 32'd0;
                    sh_b_r      <= 32'd0;
                    sh_op_r     <= 4'd0;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                    sh_en_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_shift_arb.md
ALU_SHIFT_ARB -- requirements
Module: alu_shift_arb

Interface
REQ-001 Parameter MASK_SHAMT, default 1: when 1, the shift amount forwarded to the shift unit SHALL be {27'b0, B[4:0]}; when 0, B SHALL be forwarded unmodified.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester has an operation pending.
REQ-005 req0_ready, req1_ready  output  1 each  arbiter accepts the requester's operation this cycle.
REQ-006 req0_a, req1_a  input  32 each  operand A.
REQ-007 req0_b, req1_b  input  32 each  operand B (shift amount).
REQ-008 req0_op, req1_op  input  4 each  opcode; legal values: 4'b0101 SLL, 4'b0110 SAR, 4'b0111 rotate-left, 4'b1000 rotate-right.
REQ-009 sh_a, sh_b  output  32 each  operands driven to the shared shift unit.
REQ-010 sh_opcode  output  4  opcode driven to the shift unit.
REQ-011 sh_en  output  1  enable to the shift unit.
REQ-012 sh_result  input  32  combinational result returned by the shift unit.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_data  output  32  shift result.
REQ-016 rsp_id  output  1  index of the requester that owns the response.
REQ-017 rsp_err  output  1  opcode was illegal.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, RESP; exactly one operation SHALL be in flight.
REQ-019 req0_ready/req1_ready SHALL be combinational: at most one high, and only in IDLE, only to the granted requester with valid high.
REQ-020 Arbitration: single requester valid -> grant it; both valid -> grant the one indicated by the round-robin pointer (reset value 0).
REQ-021 On each accepted handshake, the pointer SHALL move to the non-granted requester.
REQ-022 Acceptance in IDLE SHALL latch a, b, op and id into internal registers and move to ISSUE next cycle.
REQ-023 In ISSUE with a legal opcode: sh_en=1, sh_a/sh_b/sh_opcode = latched values (sh_b masked per REQ-001), sh_result captured into rsp_data at the end of that cycle, rsp_err=0, then RESP.
REQ-024 In ISSUE with an illegal opcode: sh_en=0, rsp_data=0, rsp_err=1, then RESP.
REQ-025 Outside ISSUE, sh_en, sh_a, sh_b and sh_opcode SHALL be 0.
REQ-026 In RESP, rsp_valid=1 and rsp_data, rsp_id and rsp_err SHALL stay stable until rsp_ready=1.
REQ-027 rsp_valid&rsp_ready SHALL return to IDLE next cycle; no new request SHALL be accepted in the same cycle (latency acceptance->rsp_valid = 2 cycles; minimum 3 cycles between acceptances).
REQ-028 Outside RESP, rsp_valid SHALL be 0; rsp_data, rsp_id and rsp_err SHALL be 0 from reset until the first capture.
REQ-029 Requester input changes while not accepted SHALL have no effect; valid dropping before acceptance SHALL be legal.

Reset
REQ-030 When rst=1 at a clock edge: state=IDLE, pointer=0, all latched registers and outputs 0; an in-flight operation SHALL be discarded with no response.
REQ-031 While rst=1, both ready outputs and rsp_valid SHALL be 0; rst SHALL take precedence over all other events.

Verification
REQ-032 req0 SLL, A=0x0000_0001, B=4, rsp_ready=1 -> sh_en high exactly 1 cycle, rsp_valid 2 cycles after acceptance, rsp_data=0x0000_0010, rsp_id=0, rsp_err=0.
REQ-033 Both requesters valid continuously: req0 ROL A=0x8000_0001 B=1, req1 SAR A=0x8000_0000 B=4 -> grants alternate 0,1,0,1; responses 0x0000_0003 (id 0) and 0xF800_0000 (id 1).
REQ-034 req1 op=4'b0000 -> sh_en never asserted, rsp_data=0, rsp_err=1, rsp_id=1.
REQ-035 MASK_SHAMT=1, ROR A=0x0000_00F0, B=36 -> sh_b=4, rsp_data=0x0000_000F.
REQ-036 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, both ready outputs 0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-037 rst asserted in ISSUE -> next cycle IDLE, rsp_valid=0, pointer=0, no response produced for the discarded operation.
